// File: rtl/ascensor_pkg.sv
// Shared definitions for the elevator dispatcher and the per-car controllers:
// command and floor codes, direction codes and the car FSM states.
package ascensor_pkg;

    // Dispatcher command meaning "no destination".
    localparam logic [2:0] DEST_NONE = 3'b100;

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Floor codes increase with height, so unsigned compare gives travel direction.
    localparam logic [1:0] PISO_M1 = 2'b00;
    localparam logic [1:0] PISO_1  = 2'b01;
    localparam logic [1:0] PISO_2  = 2'b10;
    localparam logic [1:0] PISO_3  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StDoorOpen
    } estado_e;

    // Codes with bit 2 set (none and the reserved ones) carry no floor.
    function automatic logic es_valido(input logic [2:0] cmd);
        return !cmd[2];
    endfunction

endpackage

// File: rtl/contador_ticks.sv
// Up-counter wrapping at MaxCount with synchronous clear; tc_o flags the
// enabled cycle whose edge completes a full period.
module contador_ticks #(
    parameter int unsigned MaxCount = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned Width = (MaxCount > 1) ? $clog2(MaxCount) : 1;
    localparam logic [Width-1:0] Last = Width'(MaxCount - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: clear wins over enable, wrap to zero on the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q == Last);

endmodule

// File: rtl/control_cabina_ascensor.sv
// Per-car elevator controller: takes the dispatcher destination code, moves the
// car one floor per TICKS_PER_FLOOR cycles, runs the door for DOOR_TICKS cycles
// and reports floor, direction and busy status.
// Optional feature: CABINA_OBSTACULO_EN makes the obstruction sensor restart
// the door timer while the door is open.
module control_cabina_ascensor
    import ascensor_pkg::*;
#(
    parameter int unsigned TICKS_PER_FLOOR = 4,
    parameter int unsigned DOOR_TICKS      = 3,
    parameter logic [1:0]  HOME_FLOOR      = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] destino_asc,
    input  logic       obstaculo,
    output logic [1:0] piso_asc,
    output logic [1:0] direccion_asc,
    output logic       ocupado_asc,
    output logic       puerta_abierta,
    output logic       llegada
);

    estado_e    state_q, state_d;
    logic [2:0] dest_q;
    logic [2:0] last_acc_q, last_acc_d;
    logic [1:0] pend_q, pend_d;
    logic       pend_valid_q, pend_valid_d;
    logic [1:0] target_q, target_d;
    logic [1:0] piso_q, piso_d;
    logic [1:0] dir_q, dir_d;
    logic       ocupado_q, ocupado_d;
    logic       puerta_q, puerta_d;
    logic       llegada_q, llegada_d;

    logic       cmd_nuevo;
    logic       acepta;
    logic [1:0] piso_acc;
    logic [1:0] piso_sig;
    logic       clr_viaje, en_viaje, tc_viaje;
    logic       clr_puerta, en_puerta, tc_puerta;

    assign en_viaje  = (state_q == StMoving);
    assign clr_viaje = (state_q != StMoving);
    assign en_puerta = (state_q == StDoorOpen);
`ifdef CABINA_OBSTACULO_EN
    // An obstruction restarts the door timer for as long as it is seen.
    assign clr_puerta = (state_q != StDoorOpen) || obstaculo;
`else
    assign clr_puerta = (state_q != StDoorOpen);
    logic unused_obstaculo;
    assign unused_obstaculo = obstaculo;
`endif

    contador_ticks #(
        .MaxCount(TICKS_PER_FLOOR)
    ) u_viaje (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_viaje),
        .en_i (en_viaje),
        .tc_o (tc_viaje)
    );

    contador_ticks #(
        .MaxCount(DOOR_TICKS)
    ) u_puerta (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(clr_puerta),
        .en_i (en_puerta),
        .tc_o (tc_puerta)
    );

    // Next-state logic: accept, travel, door timing and pending capture.
    always_comb begin
        state_d      = state_q;
        last_acc_d   = last_acc_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        target_d     = target_q;
        piso_d       = piso_q;
        dir_d        = dir_q;
        ocupado_d    = ocupado_q;
        puerta_d     = puerta_q;
        llegada_d    = 1'b0;
        acepta       = 1'b0;
        piso_acc     = pend_q;

        cmd_nuevo = es_valido(dest_q) && (dest_q != last_acc_q);
        piso_sig  = (dir_q == DIR_UP) ? piso_q + 2'd1 : piso_q - 2'd1;

        // A command arriving while busy queues, latest one wins; in IDLE it
        // queues only when the pending one is being served this cycle.
        if (cmd_nuevo && ((state_q != StIdle) || pend_valid_q)) begin
            pend_d       = dest_q[1:0];
            pend_valid_d = 1'b1;
            last_acc_d   = dest_q;
        end

        unique case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    acepta   = 1'b1;
                    piso_acc = pend_q;
                    if (!cmd_nuevo) begin
                        pend_valid_d = 1'b0;
                    end
                end else if (cmd_nuevo) begin
                    acepta     = 1'b1;
                    piso_acc   = dest_q[1:0];
                    last_acc_d = dest_q;
                end
                if (acepta) begin
                    target_d  = piso_acc;
                    ocupado_d = 1'b1;
                    if (piso_acc > piso_q) begin
                        state_d = StMoving;
                        dir_d   = DIR_UP;
                    end else if (piso_acc < piso_q) begin
                        state_d = StMoving;
                        dir_d   = DIR_DOWN;
                    end else begin
                        state_d  = StDoorOpen;
                        dir_d    = DIR_STOP;
                        puerta_d = 1'b1;
                    end
                end
            end
            StMoving: begin
                if (tc_viaje) begin
                    piso_d = piso_sig;
                    if (piso_sig == target_q) begin
                        state_d   = StDoorOpen;
                        dir_d     = DIR_STOP;
                        puerta_d  = 1'b1;
                        llegada_d = 1'b1;
                    end
                end
            end
            StDoorOpen: begin
                if (tc_puerta) begin
                    state_d   = StIdle;
                    puerta_d  = 1'b0;
                    ocupado_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; the input code is registered before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dest_q       <= DEST_NONE;
            last_acc_q   <= DEST_NONE;
            pend_q       <= PISO_M1;
            pend_valid_q <= 1'b0;
            target_q     <= HOME_FLOOR;
            piso_q       <= HOME_FLOOR;
            dir_q        <= DIR_STOP;
            ocupado_q    <= 1'b0;
            puerta_q     <= 1'b0;
            llegada_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dest_q       <= destino_asc;
            last_acc_q   <= last_acc_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            target_q     <= target_d;
            piso_q       <= piso_d;
            dir_q        <= dir_d;
            ocupado_q    <= ocupado_d;
            puerta_q     <= puerta_d;
            llegada_q    <= llegada_d;
        end
    end

    assign piso_asc       = piso_q;
    assign direccion_asc  = dir_q;
    assign ocupado_asc    = ocupado_q;
    assign puerta_abierta = puerta_q;
    assign llegada        = llegada_q;

endmodule

// File: tb/tb_control_cabina_ascensor.sv
// Directed bench for control_cabina_ascensor with default parameters
// (T = 4, D = 3, home floor 01). Door-obstruction expectations follow
// CABINA_OBSTACULO_EN.
module tb_control_cabina_ascensor;

`ifdef CABINA_OBSTACULO_EN
    localparam logic OBST = 1'b1;
`else
    localparam logic OBST = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [2:0] destino_asc;
    logic       obstaculo;
    logic [1:0] piso_asc;
    logic [1:0] direccion_asc;
    logic       ocupado_asc;
    logic       puerta_abierta;
    logic       llegada;

    int checks   = 0;
    int failures = 0;

    control_cabina_ascensor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .destino_asc   (destino_asc),
        .obstaculo     (obstaculo),
        .piso_asc      (piso_asc),
        .direccion_asc (direccion_asc),
        .ocupado_asc   (ocupado_asc),
        .puerta_abierta(puerta_abierta),
        .llegada       (llegada)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        destino_asc = 3'b100;
        obstaculo   = 1'b0;
        tick(2);
        chk2("rst_piso", piso_asc, 2'b01);
        chk2("rst_dir", direccion_asc, 2'b00);
        chk1("rst_ocupado", ocupado_asc, 1'b0);
        chk1("rst_puerta", puerta_abierta, 1'b0);
        chk1("rst_llegada", llegada, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Same-floor request at floor 1.
        destino_asc = 3'b001;
        tick(1);  // edge 0
        chk1("same_e0_ocupado", ocupado_asc, 1'b0);
        tick(1);  // edge 1
        chk1("same_e1_puerta", puerta_abierta, 1'b1);
        chk1("same_e1_ocupado", ocupado_asc, 1'b1);
        chk2("same_e1_dir", direccion_asc, 2'b00);
        tick(2);  // edge 3
        chk1("same_e3_ocupado", ocupado_asc, 1'b1);
        tick(1);  // edge 4
        chk1("same_e4_ocupado", ocupado_asc, 1'b0);
        chk1("same_e4_puerta", puerta_abierta, 1'b0);
        tick(4);  // held 001 must not be re-accepted
        chk1("same_held_ocupado", ocupado_asc, 1'b0);
        chk1("same_held_puerta", puerta_abierta, 1'b0);

        // Trip 1 -> 3, with 000 then 010 arriving mid-trip.
        destino_asc = 3'b011;
        tick(1);  // edge 0
        tick(1);  // edge 1
        chk1("up_e1_ocupado", ocupado_asc, 1'b1);
        chk2("up_e1_dir", direccion_asc, 2'b01);
        destino_asc = 3'b000;
        tick(1);  // edge 2
        destino_asc = 3'b010;
        tick(2);  // edge 4
        chk2("up_e4_piso", piso_asc, 2'b01);
        tick(1);  // edge 5
        chk2("up_e5_piso", piso_asc, 2'b10);
        chk2("up_e5_dir", direccion_asc, 2'b01);
        tick(3);  // edge 8
        chk1("up_e8_llegada", llegada, 1'b0);
        tick(1);  // edge 9
        chk2("up_e9_piso", piso_asc, 2'b11);
        chk1("up_e9_llegada", llegada, 1'b1);
        chk1("up_e9_puerta", puerta_abierta, 1'b1);
        chk2("up_e9_dir", direccion_asc, 2'b00);
        tick(1);  // edge 10
        chk1("up_e10_llegada", llegada, 1'b0);
        tick(1);  // edge 11
        chk1("up_e11_ocupado", ocupado_asc, 1'b1);
        tick(1);  // edge 12
        chk1("up_e12_ocupado", ocupado_asc, 1'b0);
        chk1("up_e12_puerta", puerta_abierta, 1'b0);
        tick(1);  // edge 13: pending 010 served, 000 was overwritten
        chk1("pend_e13_ocupado", ocupado_asc, 1'b1);
        chk2("pend_e13_dir", direccion_asc, 2'b10);
        tick(4);  // edge 17
        chk2("pend_e17_piso", piso_asc, 2'b10);
        chk1("pend_e17_llegada", llegada, 1'b1);
        chk1("pend_e17_puerta", puerta_abierta, 1'b1);
        tick(3);  // edge 20
        chk1("pend_e20_ocupado", ocupado_asc, 1'b0);
        tick(4);  // held 010 matches the last accepted code
        chk1("pend_held_ocupado", ocupado_asc, 1'b0);
        chk2("pend_held_piso", piso_asc, 2'b10);

        // Reserved and none codes are ignored.
        destino_asc = 3'b110;
        tick(4);
        chk1("inv110_ocupado", ocupado_asc, 1'b0);
        chk2("inv110_dir", direccion_asc, 2'b00);
        chk2("inv110_piso", piso_asc, 2'b10);
        destino_asc = 3'b100;
        tick(4);
        chk1("inv100_ocupado", ocupado_asc, 1'b0);
        chk1("inv100_puerta", puerta_abierta, 1'b0);
        chk2("inv100_piso", piso_asc, 2'b10);

        // Trip 2 -> 1 with an obstruction on the second door cycle.
        destino_asc = 3'b001;
        tick(2);  // edge 1
        chk2("down_e1_dir", direccion_asc, 2'b10);
        tick(4);  // edge 5 = door opens
        chk2("down_e5_piso", piso_asc, 2'b01);
        chk1("down_e5_puerta", puerta_abierta, 1'b1);
        tick(1);  // edge 6
        obstaculo = 1'b1;
        tick(1);  // edge 7
        obstaculo = 1'b0;
        tick(1);  // edge 8: fixed door time would close here
        chk1("obst_e8_puerta", puerta_abierta, OBST);
        chk1("obst_e8_ocupado", ocupado_asc, OBST);
        tick(2);  // edge 10: three cycles after the pulse
        chk1("obst_e10_puerta", puerta_abierta, 1'b0);
        chk1("obst_e10_ocupado", ocupado_asc, 1'b0);

        // Asynchronous reset mid-travel.
        destino_asc = 3'b011;
        tick(6);  // edge 5 of the trip: car at floor 2
        chk2("mid_piso", piso_asc, 2'b10);
        chk1("mid_ocupado", ocupado_asc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk2("arst_piso", piso_asc, 2'b01);
        chk2("arst_dir", direccion_asc, 2'b00);
        chk1("arst_ocupado", ocupado_asc, 1'b0);
        chk1("arst_puerta", puerta_abierta, 1'b0);
        destino_asc = 3'b100;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk1("post_rst_ocupado", ocupado_asc, 1'b0);
        chk2("post_rst_piso", piso_asc, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
